// File: rtl/vga_scan_gen_if.sv
// Raster bundle from the scan generator to the square-hit stage:
// pixel coordinates, syncs, pixel strobe and per-frame animate pulse.
interface vga_scan_gen_if;
  logic [9:0] x;
  logic [8:0] y;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       pix_en;
  logic       animate;
  logic [7:0] frame_cnt;

  modport master (
    output x, y, active, hsync, vsync, pix_en, animate, frame_cnt
  );

  modport slave (
    input x, y, active, hsync, vsync, pix_en, animate, frame_cnt
  );
endinterface

// File: rtl/vga_scan_gen.sv
// 640x480 raster timing generator: clock divider, h/v counters and a fully
// registered decode of sync, coordinates, pixel strobe and frame pulse.
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic           clk,
  input  logic           res,
  vga_scan_gen_if.master scan
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          pe_s;
  logic          act_s;

  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       pix_en_q, pix_en_d;
  logic       animate_q, animate_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    pe_s  = (div_q == DIV_LAST);
    div_d = pe_s ? {DW{1'b0}} : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (pe_s) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      h_d = h_q;
    end
  end

  // Outputs decode the counter state seen this clk, so they lag it by one.
  always_comb begin
    act_s     = (h_q < H_VIS) && (v_q < V_VIS);
    x_d       = act_s ? h_q : 10'd0;
    y_d       = act_s ? v_q[8:0] : 9'd0;
    active_d  = act_s;
    hsync_d   = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vsync_d   = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    pix_en_d  = pe_s;
    // Only the first clk of pixel (0, V_ACTIVE) fires the frame pulse.
    animate_d = (div_q == {DW{1'b0}}) && (h_q == 10'd0) && (v_q == V_VIS);
    frame_cnt_d = animate_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      div_q       <= {DW{1'b0}};
      h_q         <= 10'd0;
      v_q         <= 10'd0;
      x_q         <= 10'd0;
      y_q         <= 9'd0;
      active_q    <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      pix_en_q    <= 1'b0;
      animate_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      div_q       <= div_d;
      h_q         <= h_d;
      v_q         <= v_d;
      x_q         <= x_d;
      y_q         <= y_d;
      active_q    <= active_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      pix_en_q    <= pix_en_d;
      animate_q   <= animate_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign scan.x         = x_q;
  assign scan.y         = y_q;
  assign scan.active    = active_q;
  assign scan.hsync     = hsync_q;
  assign scan.vsync     = vsync_q;
  assign scan.pix_en    = pix_en_q;
  assign scan.animate   = animate_q;
  assign scan.frame_cnt = frame_cnt_q;

endmodule
